// File: rtl/out_arb_pkg.sv
// Shared types and constants for the out-bus round-robin arbiter.
package out_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int BEAT_CNT_W = 8;

    // Width of a requester index; never below one bit.
    function automatic int grant_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/out_arb_rr_pick.sv
// Combinational round-robin picker: nearest valid requester at or after rr_ptr.
module out_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] winner,
    output logic             any_valid
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(N_REQ);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W:0]   wrap_s;
    logic [PTR_W-1:0] idx_s;

    // Walk from the farthest offset back to rr_ptr so the nearest valid requester is assigned last.
    always_comb begin
        winner    = {PTR_W{1'b0}};
        any_valid = 1'b0;
        sum_s     = {(PTR_W + 1){1'b0}};
        wrap_s    = {(PTR_W + 1){1'b0}};
        idx_s     = {PTR_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum_s     = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            wrap_s    = sum_s - N_EXT;
            idx_s     = (sum_s >= N_EXT) ? wrap_s[PTR_W-1:0] : sum_s[PTR_W-1:0];
            winner    = req_valid[idx_s] ? idx_s : winner;
            any_valid = any_valid | req_valid[idx_s];
        end
    end

endmodule

// File: rtl/out_arbiter.sv
// Round-robin arbiter sharing the registered out bus among N_REQ requesters.
// Define OUT_ARB_PRIO_EN to make requester 0 a high-priority requester outside the rotation.
module out_arbiter
    import out_arb_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               N_REQ      = 4,
    parameter int               BURST      = 4,
    parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}}
) (
    input  logic                       ref_clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [grant_w(N_REQ)-1:0]  grant_id,
    output logic                       busy
);

    localparam int                    GRANT_W   = grant_w(N_REQ);
    localparam logic [GRANT_W-1:0]    LAST_ID   = GRANT_W'(N_REQ - 1);
    localparam logic [GRANT_W-1:0]    ONE_ID    = GRANT_W'(1);
    localparam logic [GRANT_W-1:0]    ZERO_ID   = {GRANT_W{1'b0}};
    localparam logic [BEAT_CNT_W-1:0] BURST_CNT = BEAT_CNT_W'(BURST);
    localparam logic [BEAT_CNT_W-1:0] ONE_CNT   = BEAT_CNT_W'(1);

    state_t                  state_r, state_next;
    logic [GRANT_W-1:0]      grant_id_r, grant_next;
    logic [GRANT_W-1:0]      rr_ptr_r, rr_ptr_next;
    logic [BEAT_CNT_W-1:0]   beat_cnt_r, beat_cnt_next;

    logic [N_REQ-1:0]        pick_valid_s;
    logic [GRANT_W-1:0]      pick_winner_s;
    logic                    pick_any_s;
    logic [GRANT_W-1:0]      idle_winner_s;
    logic                    idle_any_s;
    logic                    rr_update_s;
    logic [WIDTH-1:0]        lane_data_s [N_REQ];
    logic                    accept_s;
    logic                    end_burst_s;
    logic [BEAT_CNT_W-1:0]   cnt_inc_s;
    logic [GRANT_W-1:0]      rr_after_s;

`ifdef OUT_ARB_PRIO_EN
    // Requester 0 pre-empts the rotation and never advances rr_ptr.
    assign pick_valid_s  = {req_valid[N_REQ-1:1], 1'b0};
    assign idle_any_s    = req_valid[0] | pick_any_s;
    assign idle_winner_s = req_valid[0] ? ZERO_ID : pick_winner_s;
    assign rr_update_s   = (grant_id_r != ZERO_ID);
`else
    assign pick_valid_s  = req_valid;
    assign idle_any_s    = pick_any_s;
    assign idle_winner_s = pick_winner_s;
    assign rr_update_s   = 1'b1;
`endif

    out_arb_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (GRANT_W)
    ) u_pick (
        .req_valid (pick_valid_s),
        .rr_ptr    (rr_ptr_r),
        .winner    (pick_winner_s),
        .any_valid (pick_any_s)
    );

    // Split the flat data bus into per-requester lanes.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lane_data_s[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign accept_s    = (state_r == GRANT) && req_valid[grant_id_r];
    assign cnt_inc_s   = beat_cnt_r + ONE_CNT;
    assign end_burst_s = accept_s && (req_last[grant_id_r] || (cnt_inc_s == BURST_CNT));
    assign rr_after_s  = (grant_id_r == LAST_ID) ? ZERO_ID : grant_id_r + ONE_ID;
    assign grant_id    = grant_id_r;

    // Ready is a pure decode of the registered grant.
    always_comb begin
        req_ready = {N_REQ{1'b0}};
        if (state_r == GRANT) begin
            req_ready[grant_id_r] = 1'b1;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Next-state logic for the IDLE/GRANT/GAP sequencer.
    always_comb begin
        state_next    = state_r;
        grant_next    = grant_id_r;
        rr_ptr_next   = rr_ptr_r;
        beat_cnt_next = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (idle_any_s) begin
                    state_next    = GRANT;
                    grant_next    = idle_winner_s;
                    beat_cnt_next = {BEAT_CNT_W{1'b0}};
                end else begin
                    state_next    = IDLE;
                end
            end
            GRANT: begin
                if (accept_s) begin
                    beat_cnt_next = cnt_inc_s;
                end else begin
                    beat_cnt_next = beat_cnt_r;
                end
                if (end_burst_s) begin
                    state_next  = GAP;
                    rr_ptr_next = rr_update_s ? rr_after_s : rr_ptr_r;
                end else begin
                    state_next  = GRANT;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointer and output registers; reset drops any in-flight beat.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_id_r <= ZERO_ID;
            rr_ptr_r   <= ZERO_ID;
            beat_cnt_r <= {BEAT_CNT_W{1'b0}};
            out        <= IDLE_VALUE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_next;
            grant_id_r <= grant_next;
            rr_ptr_r   <= rr_ptr_next;
            beat_cnt_r <= beat_cnt_next;
            out        <= accept_s ? lane_data_s[grant_id_r] : IDLE_VALUE;
            out_valid  <= accept_s;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_out_arbiter.sv
// Directed self-checking bench for out_arbiter (WIDTH=8, N_REQ=4, BURST=4).
module tb_out_arbiter;

    logic        ref_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_last = 4'h0;
    logic [3:0]  req_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic [1:0]  grant_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Requester sources: bit 8 = last, bits 7:0 = data.
    logic [8:0] src_q [4][$];

    logic       lv [40];
    logic [7:0] ld [40];
    logic [1:0] lg [40];
    logic       lb [40];
    logic [3:0] lr [40];

    always #5 ref_clk = ~ref_clk;

    out_arbiter #(.WIDTH(8), .N_REQ(4), .BURST(4), .IDLE_VALUE(8'h00)) dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out       (out),
        .out_valid (out_valid),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic drive(input int k, input int hold_req, input int hold_from,
                         input int hold_len, input int rst_at);
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 &&
                !(i == hold_req && k >= hold_from && k < hold_from + hold_len)) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        rst = (k == rst_at);
    endtask

    // Log outputs at each negedge; sources pop only beats the arbiter really took.
    task automatic run(input int n, input int hold_req, input int hold_from,
                       input int hold_len, input int rst_at);
        logic [3:0] fire;
        logic       rst_now;
        drive(0, hold_req, hold_from, hold_len, rst_at);
        for (int j = 0; j < n; j++) begin
            @(negedge ref_clk);
            lv[j] = out_valid; ld[j] = out; lg[j] = grant_id; lb[j] = busy; lr[j] = req_ready;
            fire    = req_valid & req_ready;
            rst_now = rst;
            @(posedge ref_clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i] && !rst_now) void'(src_q[i].pop_front());
            end
            drive(j + 1, hold_req, hold_from, hold_len, rst_at);
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        req_valid = 4'h0; req_data = 32'h0; req_last = 4'h0;
        rst = 1'b1;
        repeat (2) @(posedge ref_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge ref_clk);
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        run(10, -1, 0, 0, -1);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (lv[j] !== 1'b0 || lb[j] !== 1'b0 || ld[j] !== 8'h00) begin
                errors++;
                $display("FAIL idle[%0d]: got v=%b busy=%b out=%h want 0/0/00", j, lv[j], lb[j], ld[j]);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        apply_reset();
        src_q[2].push_back(9'h011); src_q[2].push_back(9'h022); src_q[2].push_back(9'h133);
        run(8, -1, 0, 0, -1);
        checks++; if (lr[1] !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", lr[1]); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (lv[j] !== (j >= 2 && j <= 4)) begin
                errors++; $display("FAIL single_valid[%0d]: got %b want %b", j, lv[j], (j >= 2 && j <= 4));
            end
        end
        for (int j = 2; j <= 4; j++) begin
            checks++;
            if (ld[j] !== exp_d[j-2] || lg[j] !== 2'd2) begin
                errors++; $display("FAIL single_beat[%0d]: got %h/g%0d want %h/g2", j, ld[j], lg[j], exp_d[j-2]);
            end
        end
        checks++; if (lb[4] !== 1'b1 || lb[5] !== 1'b0) begin errors++; $display("FAIL single_busy: got %b%b want 10", lb[4], lb[5]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [6];
        logic [1:0] exp_g [6];
        logic [3:0] iv, kv;
        logic       ev;
        int         n;
        exp_d = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11};
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 6; k++) begin
                iv = 4'(i); kv = 4'(k);
                src_q[i].push_back({1'b1, iv, kv});
            end
        end
        run(19, -1, 0, 0, -1);
        for (int j = 0; j < 19; j++) begin
            ev = (j >= 2) && ((j - 2) % 3 == 0);
            checks++;
            if (lv[j] !== ev) begin errors++; $display("FAIL rr_valid[%0d]: got %b want %b", j, lv[j], ev); end
            if (ev) begin
                n = (j - 2) / 3;
                checks++;
                if (lg[j] !== exp_g[n] || ld[j] !== exp_d[n]) begin
                    errors++; $display("FAIL rr_grant[%0d]: got g%0d/%h want g%0d/%h", j, lg[j], ld[j], exp_g[n], exp_d[n]);
                end
            end
        end
    endtask

    task automatic test_burst_split();
        logic [11:0] exp_vm;
        logic [7:0]  exp_d [12];
        exp_vm = 12'b0011_0011_1100;
        exp_d  = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'hA5, 8'hA6, 8'h00, 8'h00};
        apply_reset();
        src_q[1].push_back(9'h0A1); src_q[1].push_back(9'h0A2); src_q[1].push_back(9'h0A3);
        src_q[1].push_back(9'h0A4); src_q[1].push_back(9'h0A5); src_q[1].push_back(9'h1A6);
        run(12, -1, 0, 0, -1);
        for (int j = 0; j < 12; j++) begin
            checks++;
            if (lv[j] !== exp_vm[j] || ld[j] !== exp_d[j]) begin
                errors++; $display("FAIL burst[%0d]: got %b/%h want %b/%h", j, lv[j], ld[j], exp_vm[j], exp_d[j]);
            end
        end
        checks++; if (lb[5] !== 1'b1 || lb[6] !== 1'b0) begin errors++; $display("FAIL burst_gap: got %b%b want 10", lb[5], lb[6]); end
        checks++; if (lg[8] !== 2'd1) begin errors++; $display("FAIL burst_regrant: got %0d want 1", lg[8]); end
    endtask

    task automatic test_stall();
        logic [12:0] exp_vm;
        logic [7:0]  exp_d [13];
        exp_vm = 13'b0_0110_0000_1100;
        exp_d  = '{8'h00, 8'h00, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'hC3, 8'hC4, 8'h00, 8'h00};
        apply_reset();
        src_q[3].push_back(9'h0C1); src_q[3].push_back(9'h0C2);
        src_q[3].push_back(9'h0C3); src_q[3].push_back(9'h1C4);
        run(13, 3, 3, 5, -1);
        for (int j = 0; j < 13; j++) begin
            checks++;
            if (lv[j] !== exp_vm[j] || ld[j] !== exp_d[j]) begin
                errors++; $display("FAIL stall[%0d]: got %b/%h want %b/%h", j, lv[j], ld[j], exp_vm[j], exp_d[j]);
            end
        end
        for (int j = 4; j <= 8; j++) begin
            checks++;
            if (lg[j] !== 2'd3 || lb[j] !== 1'b1 || lr[j] !== 4'b1000) begin
                errors++; $display("FAIL stall_hold[%0d]: got g%0d busy=%b ready=%b want g3 1 1000", j, lg[j], lb[j], lr[j]);
            end
        end
    endtask

    task automatic test_priority();
        logic [1:0] exp_g [3];
        logic [7:0] ed;
`ifdef OUT_ARB_PRIO_EN
        exp_g = '{2'd0, 2'd3, 2'd1};
`else
        exp_g = '{2'd3, 2'd0, 2'd1};
`endif
        apply_reset();
        src_q[2].push_back(9'h152);
        run(6, -1, 0, 0, -1);
        checks++; if (lv[2] !== 1'b1 || lg[2] !== 2'd2) begin errors++; $display("FAIL prio_setup: got %b/g%0d want 1/g2", lv[2], lg[2]); end
        src_q[0].push_back(9'h150); src_q[1].push_back(9'h151); src_q[3].push_back(9'h153);
        run(10, -1, 0, 0, -1);
        for (int n = 0; n < 3; n++) begin
            ed = {6'b010100, exp_g[n]};
            checks++;
            if (lv[2+3*n] !== 1'b1 || lg[2+3*n] !== exp_g[n] || ld[2+3*n] !== ed) begin
                errors++; $display("FAIL prio_order[%0d]: got %b/g%0d/%h want 1/g%0d/%h",
                                   n, lv[2+3*n], lg[2+3*n], ld[2+3*n], exp_g[n], ed);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        src_q[1].push_back(9'h161);
        run(6, -1, 0, 0, -1);
        src_q[1].push_back(9'h1E1);
        src_q[2].push_back(9'h0D1); src_q[2].push_back(9'h0D2);
        src_q[2].push_back(9'h0D3); src_q[2].push_back(9'h1D4);
        run(8, -1, 0, 0, 2);
        checks++; if (lr[1] !== 4'b0100) begin errors++; $display("FAIL rstmid_grant: got %b want 0100", lr[1]); end
        checks++; if (lv[2] !== 1'b1 || ld[2] !== 8'hD1) begin errors++; $display("FAIL rstmid_beat1: got %b/%h want 1/d1", lv[2], ld[2]); end
        checks++;
        if (lv[3] !== 1'b0 || ld[3] !== 8'h00 || lr[3] !== 4'h0 || lb[3] !== 1'b0 || lg[3] !== 2'd0) begin
            errors++; $display("FAIL rstmid_clear: got v=%b out=%h ready=%b busy=%b g%0d want 0/00/0000/0/g0",
                               lv[3], ld[3], lr[3], lb[3], lg[3]);
        end
        checks++; if (lr[4] !== 4'b0010 || lg[4] !== 2'd1) begin errors++; $display("FAIL rstmid_rrptr: got %b/g%0d want 0010/g1", lr[4], lg[4]); end
        checks++; if (lv[5] !== 1'b1 || ld[5] !== 8'hE1) begin errors++; $display("FAIL rstmid_next: got %b/%h want 1/e1", lv[5], ld[5]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_split();
        test_stall();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
